// File: rtl/store_checker.sv
// Store checker: watches CPU data-memory writes into a six-word result window
// and reaches a PASS/FAIL verdict against a fixed table of expected results.
//   clk, rst          : clock and asynchronous active-high reset
//   mem_write         : write strobe; mem_addr / mem_wdata qualify it
//   done, pass, fail  : verdict flags (done = pass | fail)
//   fail_code         : 0-5 mismatching slot, 6 timeout, 7 misaligned store
//   fail_data         : offending wdata, offending address, or seen mask
//   seen_mask         : slots that have received their correct value
//   cycle_count       : cycles spent checking, saturating
module store_checker #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0100,
  parameter int unsigned TIMEOUT   = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_write,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic [2:0]  fail_code,
  output logic [31:0] fail_data,
  output logic [5:0]  seen_mask,
  output logic [15:0] cycle_count
);

  localparam int unsigned WIN_BYTES  = 24;
  localparam logic [15:0] TIMEOUT_M1 = 16'(TIMEOUT - 1);
  localparam logic [5:0]  ALL_SEEN   = 6'h3F;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PASS = 2'd1,
    ST_FAIL = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        fail_q, fail_d;
  logic [2:0]  code_q, code_d;
  logic [31:0] data_q, data_d;
  logic [5:0]  mask_q, mask_d;
  logic [15:0] count_q, count_d;

  logic [31:0] offset;
  logic        in_win;
  logic [2:0]  slot;

  // Expected result per slot
  function automatic logic [31:0] expected_val(input logic [2:0] s);
    case (s)
      3'd0:    expected_val = 32'd8;
      3'd1:    expected_val = 32'd2;
      3'd2:    expected_val = 32'd1;
      3'd3:    expected_val = 32'd7;
      3'd4:    expected_val = 32'd1;
      3'd5:    expected_val = 32'd15;
      default: expected_val = 32'd0;
    endcase
  endfunction

  // Unsigned offset wraps below BASE_ADDR, so one compare covers both window ends
  assign offset = mem_addr - BASE_ADDR;
  assign in_win = (offset < 32'(WIN_BYTES));
  assign slot   = offset[4:2];

  // Next-state and output computation
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    data_d  = data_q;
    mask_d  = mask_q;
    count_d = count_q;

    if (state_q == ST_RUN) begin
      if (count_q != 16'hFFFF) begin
        count_d = count_q + 16'd1;
      end
      if (mem_write && in_win) begin
        if (mem_addr[1:0] != 2'b00) begin
          state_d = ST_FAIL;
          code_d  = 3'd7;
          data_d  = mem_addr;
        end else if (mem_wdata != expected_val(slot)) begin
          // Also catches corruption of a slot that was already seen
          state_d = ST_FAIL;
          code_d  = slot;
          data_d  = mem_wdata;
        end else begin
          mask_d = mask_q | (6'd1 << slot);
        end
      end
      // A store-side failure outranks completion, which outranks timeout
      if (state_d == ST_RUN) begin
        if (mask_d == ALL_SEEN) begin
          state_d = ST_PASS;
        end else if (count_q == TIMEOUT_M1) begin
          state_d = ST_FAIL;
          code_d  = 3'd6;
          data_d  = {26'b0, mask_d};
        end
      end
    end

    done_d = (state_d != ST_RUN);
    pass_d = (state_d == ST_PASS);
    fail_d = (state_d == ST_FAIL);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      code_q  <= 3'd0;
      data_q  <= 32'd0;
      mask_q  <= 6'd0;
      count_q <= 16'd0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      code_q  <= code_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      count_q <= count_d;
    end
  end

  assign done        = done_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign fail_code   = code_q;
  assign fail_data   = data_q;
  assign seen_mask   = mask_q;
  assign cycle_count = count_q;

endmodule

// File: doc/store_checker.md
STORE_CHECKER -- requirements
Module: store_checker

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h0000_0100, byte address of result slot 0.
REQ-002 The block SHALL have parameter TIMEOUT, default 100, cycles allowed in RUN before a timeout verdict.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port mem_write  input  1  CPU data-memory write strobe; one write per cycle when high.
REQ-006 The block SHALL have port mem_addr  input  32  CPU data-memory byte address.
REQ-007 The block SHALL have port mem_wdata  input  32  CPU data-memory write data.
REQ-008 The block SHALL have port done  output  1  verdict reached; high in PASS or FAIL.
REQ-009 The block SHALL have port pass  output  1  all six results were stored correctly.
REQ-010 The block SHALL have port fail  output  1  mismatch, misaligned store or timeout.
REQ-011 The block SHALL have port fail_code  output  3  0-5 mismatching slot; 6 timeout; 7 misaligned in-window store.
REQ-012 The block SHALL have port fail_data  output  32  offending wdata (mismatch), mem_addr (misaligned) or {26'b0, seen_mask} (timeout).
REQ-013 The block SHALL have port seen_mask  output  6  bit i set once slot i received its correct value.
REQ-014 The block SHALL have port cycle_count  output  16  cycles spent in RUN, saturating at 16'hFFFF.

Function
REQ-015 The expected table SHALL be fixed: slot0=8 (add), slot1=2 (sub), slot2=1 (and), slot3=7 (or), slot4=1 (slt), slot5=15 (addi).
REQ-016 The window SHALL be BASE_ADDR..BASE_ADDR+0x17; slot index = (mem_addr-BASE_ADDR)>>2.
REQ-017 Writes with mem_addr outside the window SHALL be ignored entirely.
REQ-018 The FSM SHALL have states RUN, PASS, FAIL; reset enters RUN; PASS and FAIL are sticky until rst.
REQ-019 In RUN, an in-window write with mem_addr[1:0]!=0 SHALL enter FAIL with fail_code=7, fail_data=mem_addr.
REQ-020 In RUN, an aligned in-window write whose mem_wdata equals the expected value SHALL set seen_mask[slot].
REQ-021 In RUN, an aligned in-window write whose mem_wdata differs from expected SHALL enter FAIL with fail_code=slot, fail_data=mem_wdata, including when seen_mask[slot] is already set (overwrite corruption).
REQ-022 A correct rewrite of an already-seen slot SHALL leave all state unchanged.
REQ-023 When the next seen_mask would equal 6'b111111, the FSM SHALL enter PASS on that edge.
REQ-024 cycle_count SHALL increment on every RUN cycle and hold in PASS/FAIL.
REQ-025 When cycle_count reaches TIMEOUT-1 in RUN with no other transition, the FSM SHALL enter FAIL, fail_code=6, fail_data={26'b0, seen_mask}.
REQ-026 Priority on a single edge SHALL be: misaligned/mismatch FAIL > PASS > timeout FAIL.
REQ-027 All outputs SHALL be registered; a verdict SHALL be visible the cycle after the edge that sampled the deciding write (latency 1).
REQ-028 In PASS/FAIL, mem_write SHALL be ignored and seen_mask, fail_code, fail_data SHALL hold.
REQ-029 pass, fail, done SHALL be decoded from state only; pass and fail SHALL never be high together.

Reset
REQ-030 While rst is high, independent of clk: state=RUN, done=0, pass=0, fail=0, fail_code=0, fail_data=0, seen_mask=0, cycle_count=0.
REQ-031 rst asserted mid-run or after a verdict SHALL discard all progress; checking restarts at the first rising edge after rst deasserts.

Verification
REQ-032 Writes 8,2,1,7,1,15 to 0x100..0x114 in order -> seen_mask=6'h3F, pass=1, done=1 one cycle after the 0x114 write.
REQ-033 Same six writes in reverse order, plus a write of 0x55 to 0x200 -> pass=1; the 0x200 write has no effect.
REQ-034 Write 9 to 0x104 -> fail=1, fail_code=1, fail_data=9; later correct writes leave outputs unchanged.
REQ-035 Write 2 to 0x106 -> fail=1, fail_code=7, fail_data=32'h106.
REQ-036 TIMEOUT=20, write only 0x100=8 and 0x104=2 -> fail=1, fail_code=6, fail_data=32'h3, cycle_count=20.
REQ-037 Five correct writes, then rst pulsed mid-cycle -> all outputs 0 immediately; the sixth write alone then gives seen_mask with one bit set, pass=0.
